// File: rtl/fft_input_loader.sv
// fft_input_loader: first radix-2 butterfly stage feeding the FFT working memory.
// Accepts LANES sample pairs per beat, forms C = s1 + s2 and D = s1 - s2 per
// component, and issues one registered write per beat with paired even/odd
// addresses. Tracks the beat index within a frame, checks it against in_last,
// and pulses frame completion / framing error aligned with the write strobe.
//
// Build option:
//   FFT_INPUT_SCALE_EN  - when defined, C and D are formed at WORD_SIZE+1 bits
//                         and halved (floor), so stage 1 scales by 1/2 and
//                         cannot overflow. When undefined, C and D wrap.
module fft_input_loader #(
  parameter int N         = 32,
  parameter int WORD_SIZE = 16,
  parameter int LANES     = 1,
  parameter int ADDR_W    = $clog2(N),
  parameter int BEATS     = N / (2 * LANES)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [LANES*4*WORD_SIZE-1:0]    samples,
  output logic                            wr_en,
  output logic [LANES*2*ADDR_W-1:0]       wr_addr,
  output logic [LANES*4*WORD_SIZE-1:0]    wr_data,
  output logic                            busy,
  output logic                            o_frame_done,
  output logic                            o_frame_err
);

  localparam int K_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LANE_W = 4 * WORD_SIZE;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Halve a WORD_SIZE+1 bit value with rounding toward minus infinity.
  function automatic logic signed [WORD_SIZE-1:0] round_floor_half(
    input logic signed [WORD_SIZE:0] x
  );
    return x[WORD_SIZE:1];
  endfunction

  // One butterfly output component: sum (sub = 0) or difference (sub = 1).
  function automatic logic signed [WORD_SIZE-1:0] bfly_comp(
    input logic signed [WORD_SIZE-1:0] a,
    input logic signed [WORD_SIZE-1:0] b,
    input logic                        sub
  );
`ifdef FFT_INPUT_SCALE_EN
    logic signed [WORD_SIZE:0] ax;
    logic signed [WORD_SIZE:0] bx;
    logic signed [WORD_SIZE:0] wide;
    ax   = {a[WORD_SIZE-1], a};
    bx   = {b[WORD_SIZE-1], b};
    wide = sub ? (ax - bx) : (ax + bx);
    return round_floor_half(wide);
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  // Full lane: {s1_re, s1_im, s2_re, s2_im} -> {C_re, C_im, D_re, D_im}.
  function automatic logic [LANE_W-1:0] lane_bfly(input logic [LANE_W-1:0] s);
    logic signed [WORD_SIZE-1:0] s1_re;
    logic signed [WORD_SIZE-1:0] s1_im;
    logic signed [WORD_SIZE-1:0] s2_re;
    logic signed [WORD_SIZE-1:0] s2_im;
    s1_re = s[4*WORD_SIZE-1:3*WORD_SIZE];
    s1_im = s[3*WORD_SIZE-1:2*WORD_SIZE];
    s2_re = s[2*WORD_SIZE-1:WORD_SIZE];
    s2_im = s[WORD_SIZE-1:0];
    return {bfly_comp(s1_re, s2_re, 1'b0), bfly_comp(s1_im, s2_im, 1'b0),
            bfly_comp(s1_re, s2_re, 1'b1), bfly_comp(s1_im, s2_im, 1'b1)};
  endfunction

  state_t                   state_p1;
  state_t                   state_nxt;
  logic [K_W-1:0]           k_p1;
  logic [K_W-1:0]           k_nxt;
  logic                     accept;
  logic                     last_beat;
  logic                     frame_end;
  logic [ADDR_W-1:0]        base;
  logic [LANES*2*ADDR_W-1:0] addr_p0;
  logic [LANES*LANE_W-1:0]  data_p0;

  logic                     vld_p1;
  logic [LANES*2*ADDR_W-1:0] addr_p1;
  logic [LANES*LANE_W-1:0]  data_p1;
  logic                     done_p1;
  logic                     err_p1;

  assign in_ready  = en;
  assign accept    = in_valid & en;
  assign last_beat = (k_p1 == K_W'(BEATS - 1));
  assign frame_end = last_beat | in_last;

  // Stage p0: frame position update on each accepted beat.
  always_comb begin
    state_nxt = state_p1;
    k_nxt     = k_p1;
    if (accept) begin
      if (frame_end) begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end else begin
        state_nxt = LOAD;
        k_nxt     = k_p1 + K_W'(1);
      end
    end
  end

  // Stage p0: per-lane memory addresses and butterfly results for this beat.
  always_comb begin
    base    = '0;
    addr_p0 = '0;
    data_p0 = '0;
    for (int j = 0; j < LANES; j++) begin
      base = ADDR_W'(2 * (int'(k_p1) * LANES + j));
      addr_p0[j*2*ADDR_W +: 2*ADDR_W] = {base, base | ADDR_W'(1)};
      data_p0[j*LANE_W +: LANE_W]     = lane_bfly(samples[j*LANE_W +: LANE_W]);
    end
  end

  // Frame-position state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p1 <= IDLE;
      k_p1     <= '0;
    end else begin
      state_p1 <= state_nxt;
      k_p1     <= k_nxt;
    end
  end

  // Stage p1: registered write port and frame status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1  <= accept;
      done_p1 <= accept & last_beat;
      err_p1  <= accept & (in_last ^ last_beat);
      if (accept) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign wr_en        = vld_p1;
  assign wr_addr      = addr_p1;
  assign wr_data      = data_p1;
  assign busy         = (state_p1 == LOAD);
  assign o_frame_done = done_p1;
  assign o_frame_err  = err_p1;

endmodule
